// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a valid/ready handshake.
// The extended immediate is registered; SKID=1 adds a second entry so in_ready can be registered.
module imm_gen_pipe #(
   parameter int          XLEN = 32,
   parameter int unsigned SKID = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [2:0]      immsrc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] immext,
   output logic            illegal
);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic            ill;
   } ent_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

   ent_t ext;
   logic in_fire, out_fire;
   logic unused_opcode;

   assign unused_opcode = ^instr[6:0];
   assign in_fire       = in_valid && in_ready;
   assign out_fire      = out_valid && out_ready;

   // Start from the sign fill and overwrite the low bits, so no zero-width replication at XLEN=32.
   always_comb begin
      ext = '0;
      case (immsrc)
         3'b000: begin
            ext.imm       = {XLEN{instr[31]}};
            ext.imm[11:0] = instr[31:20];
         end
         3'b001: begin
            ext.imm       = {XLEN{instr[31]}};
            ext.imm[11:0] = {instr[31:25], instr[11:7]};
         end
         3'b010: begin
            ext.imm       = {XLEN{instr[31]}};
            ext.imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         3'b011: begin
            ext.imm       = {XLEN{instr[31]}};
            ext.imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         3'b100: begin
            ext.imm       = {XLEN{instr[31]}};
            ext.imm[31:0] = {instr[31:12], 12'b0};
         end
         3'b101: ext.imm[4:0] = instr[19:15];
         3'b110: begin
            if (XLEN == 64) ext.imm[5:0] = instr[25:20];
            else            ext.imm[4:0] = instr[24:20];
         end
         default: ext.ill = 1'b1;
      endcase
   end

   if (SKID != 0) begin : g_skid
      occ_e occ_q, occ_d;
      ent_t main_q, main_d, skid_q, skid_d;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            occ_q  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
         end else begin
            occ_q  <= occ_d;
            main_q <= main_d;
            skid_q <= skid_d;
         end
      end

      always_comb begin
         occ_d  = occ_q;
         main_d = main_q;
         skid_d = skid_q;
         case (occ_q)
            EMPTY: if (in_fire) begin
               main_d = ext;
               occ_d  = ONE;
            end
            ONE: case ({in_fire, out_fire})
               2'b10: begin
                  skid_d = ext;
                  occ_d  = TWO;
               end
               2'b01: occ_d = EMPTY;
               2'b11: main_d = ext;
               default: ;
            endcase
            // in_ready is low in TWO, so only a drain can happen here.
            TWO: if (out_fire) begin
               main_d = skid_q;
               occ_d  = ONE;
            end
            default: occ_d = EMPTY;
         endcase
         if (flush) occ_d = EMPTY;
      end

      assign in_ready  = (occ_q != TWO);
      assign out_valid = (occ_q != EMPTY);
      assign immext    = main_q.imm;
      assign illegal   = main_q.ill;
   end else begin : g_single
      logic vld_q, vld_d;
      ent_t main_q, main_d;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q  <= 1'b0;
            main_q <= '0;
         end else begin
            vld_q  <= vld_d;
            main_q <= main_d;
         end
      end

      always_comb begin
         vld_d  = vld_q;
         main_d = main_q;
         if (flush) begin
            vld_d = 1'b0;
         end else if (in_fire) begin
            main_d = ext;
            vld_d  = 1'b1;
         end else if (out_fire) begin
            vld_d = 1'b0;
         end
      end

      assign in_ready  = !vld_q || out_ready;
      assign out_valid = vld_q;
      assign immext    = main_q.imm;
      assign illegal   = main_q.ill;
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit skid instance and a 64-bit single-stage instance share stimulus,
// each tracked by a queue model, plus literal expectations for the documented cases.
module tb_imm_gen_pipe;

   typedef struct packed {
      logic [63:0] imm;
      logic        ill;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] instr = '0;
   logic [2:0]  immsrc = '0;
   logic        out_ready = 1'b0;

   logic        rdy32, ov32, ill32, rdy64, ov64, ill64;
   logic [31:0] imm32;
   logic [63:0] imm64;

   int vectors = 0;
   int miscompares = 0;
   ent_t q32[$];
   ent_t q64[$];

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .SKID(1)) d32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
      .instr(instr), .immsrc(immsrc), .out_valid(ov32), .out_ready(out_ready),
      .immext(imm32), .illegal(ill32));

   imm_gen_pipe #(.XLEN(64), .SKID(0)) d64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
      .instr(instr), .immsrc(immsrc), .out_valid(ov64), .out_ready(out_ready),
      .immext(imm64), .illegal(ill64));

   // Reference extension: decode the fields as signed numbers, scale, truncate to XLEN.
   function automatic ent_t mimm(logic [31:0] ins, logic [2:0] src, int xlen);
      ent_t   r;
      longint v;
      r.ill = 1'b0;
      case (src)
         3'd0: v = longint'($signed(ins[31:20]));
         3'd1: v = longint'($signed({ins[31:25], ins[11:7]}));
         3'd2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
         3'd3: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
         3'd4: v = longint'($signed(ins[31:12])) * 4096;
         3'd5: v = longint'(ins[19:15]);
         3'd6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
         default: begin
            v     = 0;
            r.ill = 1'b1;
         end
      endcase
      r.imm = (xlen == 32) ? (v & 64'h0000_0000_FFFF_FFFF) : v;
      return r;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a FIFO of capacity 2 (skid) or 1 (single stage, pass-through ready).
   initial forever begin
      bit r32, r64;
      @(posedge clk or negedge rst_n);
      if (!rst_n || (clk && flush)) begin
         q32.delete();
         q64.delete();
      end else if (clk) begin
         r32 = q32.size() < 2;
         r64 = (q64.size() == 0) || out_ready;
         if (q32.size() != 0 && out_ready) void'(q32.pop_front());
         if (q64.size() != 0 && out_ready) void'(q64.pop_front());
         if (in_valid && r32) q32.push_back(mimm(instr, immsrc, 32));
         if (in_valid && r64) q64.push_back(mimm(instr, immsrc, 64));
      end
   end

   initial forever begin
      @(negedge clk);
      chk("rdy32", rdy32, q32.size() < 2);
      chk("ov32", ov32, q32.size() != 0);
      if (q32.size() != 0) begin
         chk("imm32", imm32, q32[0].imm);
         chk("ill32", ill32, q32[0].ill);
      end
      chk("rdy64", rdy64, (q64.size() == 0) || out_ready);
      chk("ov64", ov64, q64.size() != 0);
      if (q64.size() != 0) begin
         chk("imm64", imm64, q64[0].imm);
         chk("ill64", ill64, q64[0].ill);
      end
   end

   task automatic drv(logic v, logic [31:0] ins, logic [2:0] src, logic ordy, logic fl);
      in_valid  = v;
      instr     = ins;
      immsrc    = src;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] WA = 32'h0010_0093;
   localparam logic [31:0] WB = 32'h0020_0093;
   localparam logic [31:0] WC = 32'h0030_0093;

   logic [31:0] tbl [8];

   initial begin
      tbl = '{32'hFFF0_0093, 32'hFE11_2E23, 32'hFE00_0EE3, 32'h0080_006F,
              32'h8000_02B7, 32'h000F_D073, 32'h03F0_1093, 32'h7FF0_0093};

      repeat (2) step();
      chk("rst_ov32", ov32, 0);
      chk("rst_imm32", imm32, 0);
      chk("rst_ill32", ill32, 0);
      chk("rst_rdy32", rdy32, 1);
      chk("rst_ov64", ov64, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      step();

      // Single-format conversions at full throughput.
      drv(1, 32'hFFF0_0093, 3'd0, 1, 0); step();
      chk("I_ov", ov32, 1);
      chk("I_imm32", imm32, 32'hFFFF_FFFF);
      chk("I_ill", ill32, 0);
      chk("I_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
      drv(1, 32'hFE00_0EE3, 3'd2, 1, 0); step();
      chk("B_imm32", imm32, 32'hFFFF_FFFC);
      chk("B_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
      drv(1, 32'h0080_006F, 3'd3, 1, 0); step();
      chk("J_imm32", imm32, 32'h0000_0008);
      drv(1, 32'h8000_02B7, 3'd4, 1, 0); step();
      chk("U_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
      chk("U_imm32", imm32, 32'h8000_0000);
      drv(1, 32'h03F0_1093, 3'd6, 1, 0); step();
      chk("SH_imm64", imm64, 64'h3F);
      chk("SH_imm32", imm32, 32'h1F);
      drv(1, 32'hFE11_2E23, 3'd1, 1, 0); step();
      chk("S_imm32", imm32, 32'hFFFF_FFFC);
      drv(1, 32'h000F_D073, 3'd5, 1, 0); step();
      chk("Z_imm32", imm32, 32'h1F);
      drv(1, 32'hFFFF_FFFF, 3'd7, 1, 0); step();
      chk("RSV_imm32", imm32, 0);
      chk("RSV_ill32", ill32, 1);
      chk("RSV_imm64", imm64, 0);
      chk("RSV_ill64", ill64, 1);
      drv(0, 0, 0, 1, 0); step();
      chk("drain_ov32", ov32, 0);

      // Back-pressure fills main then skid; the third word waits.
      drv(1, WA, 3'd0, 0, 0); step();
      chk("bp_rdyA", rdy32, 1);
      chk("bp_immA", imm32, 1);
      drv(1, WB, 3'd0, 0, 0); step();
      chk("bp_rdyB", rdy32, 0);
      chk("bp_holdA", imm32, 1);
      drv(1, WC, 3'd0, 0, 0); step();
      chk("bp_stall_imm", imm32, 1);
      chk("bp_stall_rdy", rdy32, 0);
      drv(1, WC, 3'd0, 1, 0); step();
      chk("bp_outB", imm32, 2);
      chk("bp_rdy_back", rdy32, 1);
      drv(1, WC, 3'd0, 1, 0); step();
      chk("bp_outC", imm32, 3);
      drv(0, 0, 0, 1, 0); step();
      chk("bp_empty", ov32, 0);

      // Flush with two held entries and an offered word.
      drv(1, WA, 3'd0, 0, 0); step();
      drv(1, WB, 3'd0, 0, 0); step();
      drv(1, WC, 3'd0, 0, 1); step();
      chk("fl_ov32", ov32, 0);
      chk("fl_rdy32", rdy32, 1);
      chk("fl_ov64", ov64, 0);
      drv(0, 0, 0, 1, 0); step();
      chk("fl_after", ov32, 0);
      // Flush discards an input even while in_ready is high.
      drv(1, WA, 3'd0, 0, 0); step();
      drv(1, WB, 3'd0, 0, 1); step();
      chk("fl_rdy_ov32", ov32, 0);
      drv(0, 0, 0, 1, 0); step();

      // Mixed stream under irregular valid/ready.
      for (int i = 0; i < 48; i++) begin
         drv(i % 4 != 1, tbl[i % 8] ^ (i << 7), 3'(i % 8), i % 3 != 0, i == 30);
         step();
      end
      drv(0, 0, 0, 1, 0);
      repeat (3) step();

      // Asynchronous reset in the middle of a stream.
      drv(1, WA, 3'd0, 0, 0); step();
      drv(1, WB, 3'd0, 0, 0); step();
      #2 rst_n = 1'b0;
      #1;
      chk("ar_ov32", ov32, 0);
      chk("ar_imm32", imm32, 0);
      chk("ar_ill32", ill32, 0);
      chk("ar_rdy32", rdy32, 1);
      chk("ar_ov64", ov64, 0);
      chk("ar_imm64", imm64, 0);
      drv(0, 0, 0, 1, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      step();
      chk("rel_rdy32", rdy32, 1);
      chk("rel_ov32", ov32, 0);
      step();
      chk("rel_noreplay", ov32, 0);
      chk("rel_ov64", ov64, 0);

      repeat (2) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
